// File: rtl/rv32_instr_encoder.sv
// RV32I instruction word builder: packs decoded fields and a signed immediate,
// validates the immediate, tags each word with an address and buffers it in a 2-deep FIFO.
module rv32_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  input  logic             addr_load,
  input  logic [31:0]      addr_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic [1:0]       out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic signed [31:0] simm;
  logic [31:0]        packed_word;
  logic [31:0]        enc_instr;
  logic [1:0]         enc_err;

  logic [31:0]      instr_mem [2];
  logic [31:0]      addr_mem  [2];
  logic [1:0]       err_mem   [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             init_reg;
  logic [31:0]      addr_reg;
  logic [ERR_W-1:0] err_count_reg;
  logic             push;
  logic             pop;

  assign simm = imm;

  always_comb begin
    packed_word = 32'h0;
    enc_err     = 2'd0;
    case (fmt)
      3'd0: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: begin
        packed_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (simm < -2048 || simm > 2047) enc_err = 2'd1;
      end
      3'd2: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (simm < -2048 || simm > 2047) enc_err = 2'd1;
      end
      3'd3: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        // Misalignment outranks range, so it is tested first.
        if (imm[0])                          enc_err = 2'd2;
        else if (simm < -4096 || simm > 4094) enc_err = 2'd1;
      end
      3'd4: begin
        packed_word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'h000) enc_err = 2'd2;
      end
      3'd5: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])                                  enc_err = 2'd2;
        else if (simm < -1048576 || simm > 1048574) enc_err = 2'd1;
      end
      default: enc_err = 2'd3;
    endcase
    enc_instr = (enc_err != 2'd0) ? NOP : packed_word;
  end

  // init_reg keeps the input side closed for the first cycle after reset.
  assign in_ready  = init_reg && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr = instr_mem[rd_ptr_reg];
  assign out_addr  = addr_mem[rd_ptr_reg];
  assign out_err   = err_mem[rd_ptr_reg];
  assign err_count = err_count_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + 2'd1;
    else if (pop && !push) count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_reg      <= 1'b0;
      count_reg     <= 2'd0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      addr_reg      <= BASE_ADDR;
      err_count_reg <= '0;
      for (int i = 0; i < 2; i++) begin
        instr_mem[i] <= 32'h0;
        addr_mem[i]  <= 32'h0;
        err_mem[i]   <= 2'd0;
      end
    end else begin
      init_reg  <= 1'b1;
      count_reg <= count_next;
      if (push) begin
        instr_mem[wr_ptr_reg] <= enc_instr;
        addr_mem[wr_ptr_reg]  <= addr_reg;
        err_mem[wr_ptr_reg]   <= enc_err;
        wr_ptr_reg            <= ~wr_ptr_reg;
        if (enc_err != 2'd0 && err_count_reg != {ERR_W{1'b1}})
          err_count_reg <= err_count_reg + ERR_W'(1);
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      // A load wins over the post-push increment; the pushed word already took the old value.
      if (addr_load)  addr_reg <= {addr_val[31:2], 2'b00};
      else if (push)  addr_reg <= addr_reg + 32'd4;
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed plus randomized bench for rv32_instr_encoder against an arithmetic reference model.
module tb_rv32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_val = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] out_instr, out_addr, out_instr2, out_addr2;
  logic [1:0]  out_err, out_err2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;

  int checks = 0;
  int failures = 0;

  logic [31:0] q_instr[$];
  logic [31:0] q_addr[$];
  logic [1:0]  q_err[$];
  logic [31:0] model_addr = 32'h0;
  int          model_errs = 0;

  always #5 clk = ~clk;

  rv32_instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_load(addr_load), .addr_val(addr_val), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .err_count(err_count));

  rv32_instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .fmt(fmt),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_load(addr_load), .addr_val(addr_val), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
    .out_err(out_err2), .err_count(err_count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from field weights and integer range tests.
  function automatic logic [33:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] im);
    longint      si;
    logic [31:0] w, base;
    logic [1:0]  e;
    si   = longint'($signed(im));
    e    = 2'd0;
    w    = 32'h0;
    base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: w = (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
      3'd1: begin
        w = ((im & 32'hFFF) << 20) | base | (32'(d) << 7);
        if (si < -2048 || si > 2047) e = 2'd1;
      end
      3'd2: begin
        w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((im & 32'h1F) << 7);
        if (si < -2048 || si > 2047) e = 2'd1;
      end
      3'd3: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) |
            base | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
        if ((im & 32'h1) != 0)          e = 2'd2;
        else if (si < -4096 || si > 4094) e = 2'd1;
      end
      3'd4: begin
        w = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
        if ((im & 32'hFFF) != 0) e = 2'd2;
      end
      3'd5: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) |
            (32'(d) << 7) | 32'(op);
        if ((im & 32'h1) != 0)                  e = 2'd2;
        else if (si < -1048576 || si > 1048574) e = 2'd1;
      end
      default: e = 2'd3;
    endcase
    if (e != 2'd0) w = 32'h0000_0013;
    return {e, w};
  endfunction

  // Drives one field set from a negedge and returns at the negedge after acceptance.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im);
    logic [33:0] r;
    int n = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    if (in_ready) begin
      r = model(f, op, d, s1, s2, f3, f7, im);
      q_instr.push_back(r[31:0]);
      q_err.push_back(r[33:32]);
      q_addr.push_back(model_addr);
      if (r[33:32] != 2'd0) model_errs++;
      model_addr = addr_load ? {addr_val[31:2], 2'b00} : model_addr + 32'd4;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic expect_last(input logic [31:0] instr, input logic [1:0] err);
    q_instr[q_instr.size()-1] = instr;
    q_err[q_err.size()-1]     = err;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q_instr.size() > 0 && n < 40) begin
      if (out_valid) begin
        chk("out_instr", out_instr, q_instr[0]);
        chk("out_addr", out_addr, q_addr[0]);
        chk("out_err", 32'(out_err), 32'(q_err[0]));
        chk("sat_out_instr", out_instr2, q_instr[0]);
        void'(q_instr.pop_front());
        void'(q_addr.pop_front());
        void'(q_err.pop_front());
      end
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(q_instr.size()), 32'd0);
    out_ready = 1'b0;
    chk("empty_after_drain", 32'(out_valid), 32'd0);
    chk("err_count", 32'(err_count), 32'(model_errs > 255 ? 255 : model_errs));
    chk("err_count_sat", 32'(err_count2), 32'(model_errs > 3 ? 3 : model_errs));
  endtask

  int bounds[17] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                     -1048577, -1048576, 1048574, 1048576, 0, 1, -1, 32'h12345000};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // lw x0,-1(x0): out_valid one cycle after accept
    send(3'd1, 7'b0000011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    expect_last(32'hFFF0_0003, 2'd0);
    chk("latency1_valid", 32'(out_valid), 32'd1);
    drain();

    // sw, beq, jal at 4, 8, C
    send(3'd2, 7'b0100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32);
    expect_last(32'hFE00_0023, 2'd0);
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -2);
    expect_last(32'hFE00_0FE3, 2'd0);
    drain();
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_last(32'h0010_00EF, 2'd0);
    chk("jal_addr", out_addr, 32'hC);
    drain();

    // Four distinct error classes, then a fifth to saturate the 2-bit counter
    send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_last(32'h0000_0013, 2'd1);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    expect_last(32'h0000_0013, 2'd2);
    drain();
    send(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234);
    expect_last(32'h0000_0013, 2'd2);
    send(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    expect_last(32'h0000_0013, 2'd3);
    drain();
    chk("err_count_4", 32'(err_count), 32'd4);
    send(3'd6, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    drain();
    chk("err_count_sat_3", 32'(err_count2), 32'd3);

    // Backpressure: three back-to-back offers, only two fit
    send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    send(3'd1, 7'b0010011, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd100);
    fmt = 3'd0; in_valid = 1'b1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", out_instr, q_instr[0]);
    @(negedge clk);
    chk("full_in_ready_hold", 32'(in_ready), 32'd0);
    chk("head_stable", out_instr, q_instr[0]);
    chk("head_addr_stable", out_addr, q_addr[0]);
    in_valid = 1'b0;
    drain();

    // Load concurrent with a push, then wraparound
    addr_load = 1'b1; addr_val = 32'h0000_1003;
    send(3'd0, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    send(3'd0, 7'b0110011, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("loaded_addr", q_addr[1], 32'h0000_1000);
    drain();
    addr_load = 1'b1; addr_val = 32'hFFFF_FFFC;
    @(negedge clk);
    addr_load = 1'b0;
    model_addr = 32'hFFFF_FFFC;
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    send(3'd4, 7'b0010111, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
    chk("wrap_addr", q_addr[1], 32'h0);
    drain();

    // Randomized field sets mixed with boundary immediates
    for (int i = 0; i < 60; i++) begin
      logic [31:0] im;
      im = ($urandom_range(0, 1) == 0) ? 32'(bounds[$urandom_range(0, 16)]) : $urandom;
      send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom), im);
      if (i % 2 == 1) drain();
    end

    // Reset with two words buffered
    send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5000);
    #1 rst = 1'b1;
    #1;
    chk("rst_flush_valid", 32'(out_valid), 32'd0);
    q_instr.delete(); q_addr.delete(); q_err.delete();
    model_addr = 32'h0;
    model_errs = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    send(3'd1, 7'b0010011, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'd7);
    chk("post_rst_addr", out_addr, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Builds 32-bit RV32I instruction words from decoded fields plus a full-width signed immediate. It is the inverse of the immediate generator.
- Packs the immediate into the I/S/B/U/J bit scatter, range- and alignment-checks it, and tags each word with a sequential program address.
- Feeds the instruction-memory loader and the self-check bench stimulus path through a 2-entry output buffer with valid/ready on both sides.

Parameters:
- BASE_ADDR, 32'h0000_0000: address tagged on the first word after reset.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  field set present
- in_ready  out  1  encoder can accept a field set this cycle
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- opcode  in  7  inst[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  inst[14:12]
- funct7  in  7  inst[31:25], R only
- imm  in  32  signed byte offset/value (U: full 32-bit value)
- addr_load  in  1  load address counter
- addr_val  in  32  value for addr_load, bits[1:0] forced 0
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer takes word
- out_instr  out  32  encoded instruction
- out_addr  out  32  address of out_instr
- out_err  out  2  0 ok, 1 range, 2 misaligned, 3 bad fmt
- err_count  out  ERR_W  saturating count of words with out_err!=0

Behaviour:
- Reset values: FIFO empty; out_valid=0; out_instr=0; out_err=0; addr counter=BASE_ADDR; err_count=0. in_ready is 1 one cycle after rst deasserts. rst asserted mid-operation flushes buffered words without emitting them.
- Accept: in_valid&in_ready. The word is encoded combinationally and written into the FIFO on that edge. out_valid rises the next cycle when the FIFO was empty (latency 1).
- in_ready = (count<2). It depends only on registered count, never on out_ready. When count==2 and a pop occurs in the same cycle, no push is accepted that cycle.
- Pop: out_valid&out_ready. out_instr/out_addr/out_err show the FIFO head and hold stable while out_valid&!out_ready.
- Address: it is assigned at push as the current counter value, and the counter then advances by 4, wrapping mod 2^32. addr_load overrides the increment in the same cycle and applies to the next push.
- Packing:
  - R: funct7,rs2,rs1,funct3,rd,opcode.
  - I: imm[11:0],rs1,funct3,rd,opcode.
  - S: imm[11:5],rs2,rs1,funct3,imm[4:0],opcode.
  - B: imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode.
  - U: imm[31:12],rd,opcode.
  - J: imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode.
- Checks, priority bad fmt > misaligned > range:
  - I/S: imm in [-2048,2047].
  - B: imm in [-4096,4094] and imm[0]=0.
  - J: imm in [-1048576,1048574] and imm[0]=0.
  - U: imm[11:0]=0, else misaligned.
  - R: imm ignored.
- On any error: out_instr=32'h0000_0013 (NOP), the address is still consumed, out_err carries the code, and err_count increments at push, saturating at all-ones.
- opcode is passed through unchecked. The format alone selects the packing.

Test Plan:
- I lw: fmt=1, opcode=0000011, rd=0, rs1=0, funct3=0, imm=-1 -> out_instr=FFF00003, out_err=0, out_addr=0, out_valid one cycle after accept.
- S/B: sw with imm=-32 -> FE000023. beq with rs1=rs2=0, imm=-2 -> FE000FE3. J with rd=1, opcode=1101111, imm=2048 -> 001000EF. Each word's address increments by 4 (4, 8, C).
- Errors:
  - I imm=2048 -> 00000013, out_err=1.
  - B imm=3 -> out_err=2.
  - U imm=0x1234 -> out_err=2.
  - fmt=7 -> out_err=3.
  - err_count=4 after these four; with ERR_W=2 it saturates at 3 after a fifth error.
- Backpressure: hold out_ready=0 and drive 3 back-to-back valid inputs -> only 2 accepted, in_ready=0, the head word stable. Release out_ready -> words emerge in order, no loss or duplication.
- addr_load=1 with addr_val=0x1003 while a push occurs -> that push takes the old address and the next word gets 0x1000. A counter at FFFFFFFC wraps to 0 after one push.
- Assert rst with 2 words buffered -> out_valid=0 immediately. After release: err_count=0, next out_addr=BASE_ADDR.
